// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings and helpers for the load/store sequencer.
package lsu_ctrl_pkg;

    localparam int unsigned XREG_ADDRWIDTH = 5;
    localparam int unsigned LSU_TIMEOUT    = 16;

    // Upstream load/store type flags (one-hot, zero = no access).
    localparam logic [4:0] NO_LOAD  = 5'b00000;
    localparam logic [4:0] LOAD_B   = 5'b00001;
    localparam logic [4:0] LOAD_H   = 5'b00010;
    localparam logic [4:0] LOAD_W   = 5'b00100;
    localparam logic [4:0] LOAD_BU  = 5'b01000;
    localparam logic [4:0] LOAD_HU  = 5'b10000;

    localparam logic [2:0] NO_STORE = 3'b000;
    localparam logic [2:0] STORE_B  = 3'b001;
    localparam logic [2:0] STORE_H  = 3'b010;
    localparam logic [2:0] STORE_W  = 3'b100;

    // Byte-lane base masks, shifted by the low address bits.
    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WB
    } lsu_state_e;

    typedef enum logic [2:0] {
        OP_LB,
        OP_LH,
        OP_LW,
        OP_LBU,
        OP_LHU,
        OP_SB,
        OP_SH,
        OP_SW
    } lsu_op_e;

    // Collapse the flag pair into one operation; a load wins over a store.
    function automatic lsu_op_e decode_op(input logic [4:0] lf, input logic [2:0] sf);
        lsu_op_e op;
        if (lf != NO_LOAD) begin
            case (lf)
                LOAD_B:  op = OP_LB;
                LOAD_H:  op = OP_LH;
                LOAD_BU: op = OP_LBU;
                LOAD_HU: op = OP_LHU;
                default: op = OP_LW;
            endcase
        end else begin
            case (sf)
                STORE_B: op = OP_SB;
                STORE_H: op = OP_SH;
                default: op = OP_SW;
            endcase
        end
        return op;
    endfunction

    function automatic logic op_is_store(input lsu_op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_aligned(input lsu_op_e op, input logic [1:0] lo);
        logic ok;
        case (op)
            OP_LH, OP_LHU, OP_SH: ok = (lo[0] == 1'b0);
            OP_LW, OP_SW:         ok = (lo == 2'b00);
            default:              ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] op_strb(input lsu_op_e op, input logic [1:0] lo);
        logic [3:0] s;
        case (op)
            OP_SB:   s = STRB_B << lo;
            OP_SH:   s = STRB_H << lo;
            OP_SW:   s = STRB_W;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Single data-memory port: req/ack handshake with byte strobes.
interface lsu_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl_load_fmt.sv
// Load result formatter: lane select by low address bits, then extension.
module lsu_ctrl_load_fmt
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      addr_lo_i,
    input  lsu_op_e         op_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = 8'(rdata_i >> {addr_lo_i, 3'b000});
    assign half_sel = 16'(rdata_i >> {addr_lo_i, 3'b000});

    // Pick the addressed lane and sign/zero extend to XLEN.
    always_comb begin
        data_o = rdata_i;
        case (op_i)
            OP_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            OP_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between EXU and the data-memory port.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic [4:0]                load_flag_in,
    input  logic [2:0]                store_flag_in,
    input  logic [XLEN-1:0]           addr_in,
    input  logic [XLEN-1:0]           store_data_in,
    input  logic                      rd_en_in,
    input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
    output logic                      stall_out,
    lsu_ctrl_if.master                mem,
    output logic                      wb_valid,
    output logic [XREG_ADDRWIDTH-1:0] wb_rd_addr,
    output logic [XLEN-1:0]           wb_data,
    output logic                      misalign_out,
    output logic                      bus_err_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e                state_q;
    lsu_op_e                   op_q;
    logic [1:0]                addr_lo_q;
    logic                      rd_en_q;
    logic [XREG_ADDRWIDTH-1:0] rd_addr_q;
    logic [CNT_W-1:0]          cnt_q;

    logic                      mem_req_q;
    logic                      mem_we_q;
    logic [XLEN-1:0]           mem_addr_q;
    logic [XLEN-1:0]           mem_wdata_q;
    logic [3:0]                mem_wstrb_q;

    logic                      wb_valid_q;
    logic [XREG_ADDRWIDTH-1:0] wb_rd_addr_q;
    logic [XLEN-1:0]           wb_data_q;
    logic [XLEN-1:0]           wb_data_d;

    lsu_op_e                   in_op;
    logic                      start;
    logic                      aligned;
    logic                      in_idle;
    logic                      in_req;
    logic                      cur_store;
    logic                      timeout_hit;

    function automatic logic [XLEN-1:0] store_lanes(input lsu_op_e op, input logic [XLEN-1:0] d);
        logic [XLEN-1:0] w;
        case (op)
            OP_SB:   w = {(XLEN/8){d[7:0]}};
            OP_SH:   w = {(XLEN/16){d[15:0]}};
            OP_SW:   w = d;
            default: w = '0;
        endcase
        return w;
    endfunction

    assign in_op       = decode_op(load_flag_in, store_flag_in);
    assign start       = valid_in && ((load_flag_in != NO_LOAD) || (store_flag_in != NO_STORE));
    assign aligned     = op_aligned(in_op, addr_in[1:0]);
    assign in_idle     = (state_q == LSU_IDLE);
    assign in_req      = (state_q == LSU_REQ);
    assign cur_store   = op_is_store(op_q);
    assign timeout_hit = in_req && !mem.mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cycle-exact status: these react to the current inputs and ack.
    assign misalign_out = in_idle && start && !aligned;
    assign bus_err_out  = timeout_hit;
    assign stall_out    = (in_idle && start && aligned) || (in_req && !(mem.mem_ack && cur_store));

    lsu_ctrl_load_fmt #(
        .XLEN (XLEN)
    ) u_fmt (
        .rdata_i   (mem.mem_rdata),
        .addr_lo_i (addr_lo_q),
        .op_i      (op_q),
        .data_o    (wb_data_d)
    );

    // Sequencer FSM with registered bus and writeback outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            op_q         <= OP_LB;
            addr_lo_q    <= '0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_data_q    <= '0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                LSU_IDLE: begin
                    if (start && aligned) begin
                        op_q        <= in_op;
                        addr_lo_q   <= addr_in[1:0];
                        rd_en_q     <= rd_en_in;
                        rd_addr_q   <= rd_addr_in;
                        cnt_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= op_is_store(in_op);
                        mem_addr_q  <= {addr_in[XLEN-1:2], 2'b00};
                        mem_wdata_q <= store_lanes(in_op, store_data_in);
                        mem_wstrb_q <= op_strb(in_op, addr_in[1:0]);
                        state_q     <= LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    // Ack has priority over a timeout in the same cycle.
                    if (mem.mem_ack) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= '0;
                        if (cur_store) begin
                            state_q <= LSU_IDLE;
                        end else begin
                            wb_valid_q   <= rd_en_q && (rd_addr_q != '0);
                            wb_rd_addr_q <= rd_addr_q;
                            wb_data_q    <= wb_data_d;
                            state_q      <= LSU_WB;
                        end
                    end else if (timeout_hit) begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wstrb_q <= '0;
                        state_q     <= LSU_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LSU_WB: begin
                    state_q <= LSU_IDLE;
                end
                default: begin
                    state_q <= LSU_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;

    assign wb_valid   = wb_valid_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_data    = wb_data_q;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store sequencer in the EXU/MEM boundary.
- Takes the effective address, load/store type flags, store data and destination register produced by the ALU for one instruction.
- Runs the single data-memory port with a req/ack handshake: byte-lane strobes, word-aligned address, load extraction with sign/zero extension.
- Stalls the upstream pipeline while a transfer is outstanding, then presents load results for register writeback.

Parameters:
- XLEN, 32, data/address width (matches `XLEN in config.v).
- TIMEOUT_CYCLES, 16, max cycles in REQ without mem_ack before bus error.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- valid_in  in  1  upstream instruction valid this cycle.
- load_flag_in  in  5  `NO_LOAD/`LOAD_B/`LOAD_H/`LOAD_W/`LOAD_BU/`LOAD_HU.
- store_flag_in  in  3  `NO_LOAD/`STORE_B/`STORE_H/`STORE_W.
- addr_in  in  XLEN  effective address (ALU rd_out).
- store_data_in  in  XLEN  rs2 value.
- rd_en_in  in  1  instruction writes rd.
- rd_addr_in  in  `XREG_ADDRWIDTH  destination register.
- stall_out  out  1  upstream must hold its stage.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  XLEN  word-aligned address.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_wstrb  out  4  byte-lane enables (writes only; 0 on reads).
- mem_ack  in  1  memory completes the current request.
- mem_rdata  in  XLEN  read word, valid with mem_ack.
- wb_valid  out  1  load writeback pulse.
- wb_rd_addr  out  `XREG_ADDRWIDTH  writeback register.
- wb_data  out  XLEN  formatted load data.
- misalign_out  out  1  one-cycle misaligned-access pulse.
- bus_err_out  out  1  one-cycle timeout pulse.

Behaviour:
- Reset: state IDLE. All outputs 0, including mem_addr, mem_wdata and wb_data. Captured registers and timeout counter cleared.
- Reset mid-transfer drops mem_req immediately (asynchronous). The transfer is abandoned and no wb_valid is produced.
- States: IDLE, REQ, WB.
- start = valid_in & (load_flag_in != `NO_LOAD or store_flag_in != `NO_LOAD).
  - If both flags are non-`NO_LOAD, load wins.
- Alignment rule:
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=0.
  - B/BU are always aligned.
- IDLE + start + misaligned:
  - misalign_out=1 for that cycle.
  - No request is issued, state stays IDLE, stall_out=0.
- IDLE + start + aligned:
  - Capture type, addr, data, rd_en and rd_addr.
  - Next state REQ; stall_out=1 in this cycle.
- REQ:
  - mem_req=1.
  - mem_addr = {addr[XLEN-1:2],2'b00}, held stable until mem_ack.
  - Store:
    - mem_we=1.
    - B: wstrb = 4'b0001<<addr[1:0], wdata = {4{d[7:0]}}.
    - H: wstrb = 4'b0011<<addr[1:0], wdata = {2{d[15:0]}}.
    - W: wstrb = 4'hF, wdata = d.
  - Load: mem_we=0, wstrb=0.
- REQ + mem_ack:
  - Store: go to IDLE, stall_out=0 in the ack cycle.
  - Load: latch mem_rdata, go to WB, stall_out=1 in the ack cycle.
- WB:
  - wb_valid = captured rd_en & (rd_addr != 0).
  - wb_data: byte/half selected by addr[1:0] (rdata >> 8*addr[1:0]), then extended.
    - B/H sign-extend; BU/HU zero-extend; W passes through.
  - stall_out=0. Next state IDLE.
  - A new start in the cycle after WB is accepted normally.
- Timeout:
  - Counter is cleared on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack: bus_err_out=1, mem_req drops next cycle, state IDLE, no writeback.
  - mem_ack on that same cycle takes priority over the timeout.
- stall_out = (IDLE & start & aligned) | (REQ & ~(mem_ack & store)) | 0 in WB.
- Latency: load issue T0, earliest ack T1, wb_valid T2. Store completes at T1 if acked immediately.
- Inputs are sampled only in IDLE; changes while stalled are ignored.

Decomposition:
- Add to config.v:
  - LSU state encodings (LSU_IDLE/LSU_REQ/LSU_WB).
  - STRB_B/STRB_H/STRB_W base masks.
  - LSU_TIMEOUT default.
- Reuse the existing LOAD_*/STORE_*/NO_LOAD flags.
- One combinational sub-module: lsu_load_fmt (rdata, addr[1:0], load type -> wb_data).

Test Plan:
1. SW, addr 0x100, data 0xDEADBEEF, ack after 2 cycles -> mem_addr=0x100, wstrb=F, wdata=0xDEADBEEF; stall_out high 3 cycles, low on the ack cycle; no wb_valid.
2. SB, addr 0x103, data 0x000000A5 -> mem_addr=0x100, wstrb=4'b1000, wdata=0xA5A5A5A5.
3. LB, addr 0x102, rd=5, rdata 0x1280FF00 -> wb_valid at T2, wb_rd_addr=5, wb_data=0xFFFFFF80. Same access as LBU -> 0x00000080.
4. LH at 0x101 and LW at 0x102 -> misalign_out pulse, mem_req never asserted, stall_out=0.
5. LW, no ack for 16 cycles -> bus_err_out pulse on the 16th REQ cycle, mem_req low next cycle, no wb_valid. Repeat with ack on the 16th cycle -> normal writeback, no bus error.
6. LW with ack pending, rst asserted mid-REQ -> mem_req, stall_out and wb_valid drop immediately. After release, a new SW completes normally. LW with rd=0 -> no wb_valid.
